// File: rtl/efuse_reg_loader.sv
// efuse_reg_loader: post-reset sequencer that reads NUM_WORDS efuse words
// over a req/ack handshake and writes each one into the register bank via
// the logic-write port at BASE_ADDR + index (wrapping modulo 2^AW).
// Every output is driven straight from a flop, so the block is a pure Moore
// machine as seen from outside.
//
// Efuse handshake: o_efuse_req is a level that rises with o_efuse_addr stable
// and stays high until i_efuse_ack is sampled high at a clock edge. The ack
// and i_efuse_rdata are taken in that same edge. Ack is ignored whenever req
// is low. If ack has not arrived after TIMEOUT request cycles, the run aborts
// into the error state.

module efuse_reg_loader #(
    parameter int            DW         = 8,
    parameter int            AW         = 8,
    parameter int            NUM_WORDS  = 16,
    parameter logic [AW-1:0] BASE_ADDR  = 8'h40,
    parameter int            TIMEOUT    = 255,
    parameter logic          AUTO_START = 1'b1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_start,
    output logic          o_efuse_req,
    output logic [AW-1:0] o_efuse_addr,
    input  logic          i_efuse_ack,
    input  logic [DW-1:0] i_efuse_rdata,
    output logic          o_lgc_wen,
    output logic [AW-1:0] o_lgc_addr,
    output logic [DW-1:0] o_lgc_wdata,
    output logic          o_efuse_ctrl_reg_en,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_err,
    output logic [2:0]    o_dbg_state
);

    // Word counter is at least one bit wide, even for a single-word run.
    localparam int CW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [CW-1:0] LAST_WORD = CW'(NUM_WORDS - 1);
    // The timer starts at 0 on the first request cycle. Therefore TIMEOUT-1
    // marks the last cycle in which an ack can still be accepted.
    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WRITE = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cnt_inc;
    logic [7:0]    timer_q, timer_d;
    logic          auto_q, auto_d;
    logic          req_q, req_d;
    logic [AW-1:0] efuse_addr_q, efuse_addr_d;
    logic          wen_q, wen_d;
    logic [AW-1:0] lgc_addr_q, lgc_addr_d;
    logic [DW-1:0] lgc_wdata_q, lgc_wdata_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          start_go;

    // auto_q is set by reset and cleared on the first edge after release.
    // It therefore acts as a one-shot start request.
    assign start_go = i_start | auto_q;
    assign cnt_inc  = cnt_q + CW'(1);

    // State register and all registered outputs; reset clears everything.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            timer_q      <= '0;
            auto_q       <= AUTO_START;
            req_q        <= 1'b0;
            efuse_addr_q <= '0;
            wen_q        <= 1'b0;
            lgc_addr_q   <= '0;
            lgc_wdata_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            timer_q      <= timer_d;
            auto_q       <= auto_d;
            req_q        <= req_d;
            efuse_addr_q <= efuse_addr_d;
            wen_q        <= wen_d;
            lgc_addr_q   <= lgc_addr_d;
            lgc_wdata_q  <= lgc_wdata_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    // Next state and next registered outputs; everything holds unless the
    // current state changes it, except the write strobe, which is one cycle.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        timer_d      = timer_q;
        auto_d       = 1'b0;
        req_d        = req_q;
        efuse_addr_d = efuse_addr_q;
        wen_d        = 1'b0;
        lgc_addr_d   = lgc_addr_q;
        lgc_wdata_d  = lgc_wdata_q;
        busy_d       = busy_q;
        done_d       = done_q;
        err_d        = err_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start_go) begin
                    state_d      = S_REQ;
                    cnt_d        = '0;
                    timer_d      = '0;
                    req_d        = 1'b1;
                    efuse_addr_d = '0;
                    busy_d       = 1'b1;
                    done_d       = 1'b0;
                    err_d        = 1'b0;
                end
            end

            S_REQ: begin
                // Ack is checked before the timeout, so an ack on the last
                // allowed cycle still completes the word.
                if (i_efuse_ack) begin
                    state_d     = S_WRITE;
                    req_d       = 1'b0;
                    wen_d       = 1'b1;
                    lgc_addr_d  = BASE_ADDR + AW'(cnt_q);
                    lgc_wdata_d = i_efuse_rdata;
                end else if (timer_q == TIMER_LAST) begin
                    state_d = S_ERR;
                    req_d   = 1'b0;
                    busy_d  = 1'b0;
                    err_d   = 1'b1;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end

            S_WRITE: begin
                if (cnt_q == LAST_WORD) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d      = S_REQ;
                    cnt_d        = cnt_inc;
                    timer_d      = '0;
                    req_d        = 1'b1;
                    efuse_addr_d = AW'(cnt_inc);
                end
            end

            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign o_efuse_req         = req_q;
    assign o_efuse_addr        = efuse_addr_q;
    assign o_lgc_wen           = wen_q;
    assign o_lgc_addr          = lgc_addr_q;
    assign o_lgc_wdata         = lgc_wdata_q;
    assign o_busy              = busy_q;
    // The register bank accepts logic writes only while a run is in progress.
    assign o_efuse_ctrl_reg_en = busy_q;
    assign o_done              = done_q;
    assign o_err               = err_q;
    assign o_dbg_state         = state_q;

endmodule

// File: tb/tb_efuse_reg_loader.sv
// Bench for efuse_reg_loader: an efuse responder with per-word ack delays,
// a write/request-length scoreboard fed by a run-level schedule model, and
// directed plus randomized runs.

module tb_efuse_reg_loader;

    localparam int         DW   = 8;
    localparam int         AW   = 8;
    localparam int         NW   = 4;
    localparam int         TO   = 10;
    localparam logic [7:0] BASE = 8'hFE;
    localparam int         W    = 48;   // {cycle[31:0], addr[7:0], data[7:0]}

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          ack = 1'b0;
    logic [DW-1:0] rdata = '0;
    logic          req;
    logic [AW-1:0] efuse_addr;
    logic          wen;
    logic [AW-1:0] lgc_addr;
    logic [DW-1:0] lgc_wdata;
    logic          ctrl_en;
    logic          busy;
    logic          done;
    logic          err;
    logic [2:0]    dbg_state;

    efuse_reg_loader #(
        .DW(DW), .AW(AW), .NUM_WORDS(NW), .BASE_ADDR(BASE),
        .TIMEOUT(TO), .AUTO_START(1'b1)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
        .o_efuse_req(req), .o_efuse_addr(efuse_addr),
        .i_efuse_ack(ack), .i_efuse_rdata(rdata),
        .o_lgc_wen(wen), .o_lgc_addr(lgc_addr), .o_lgc_wdata(lgc_wdata),
        .o_efuse_ctrl_reg_en(ctrl_en), .o_busy(busy),
        .o_done(done), .o_err(err), .o_dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;   // number of rising edges seen so far
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    int           exp_req_q[$];
    int           dly[256];
    logic [7:0]   dat[256];
    int           n_chk = 0;
    int           n_err = 0;
    int           n_wr = 0;
    int           rlen = 0;
    logic         force_ack = 1'b0;
    int           end_cyc = 0;
    logic         end_err = 1'b0;
    int           s_cyc = 0;
    int           wr0 = 0;
    int           i_wait;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s act=%0h exp=%0h (cyc %0d)", tag, act, exp, cyc);
        end
    endtask

    // Advance to the next falling edge, then run the responder and the monitor.
    task automatic step();
        logic [W-1:0] e;
        @(negedge clk);
        if (!rst_n) begin
            rlen = 0;
            ack  = 1'b0;
        end else begin
            if (wen) begin
                n_wr++;
                if (exp_q.size() == 0) begin
                    check_val("wr_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check_val("wr_cyc", cyc, e[47:16]);
                    check_val("wr_addr", lgc_addr, e[15:8]);
                    check_val("wr_data", lgc_wdata, e[7:0]);
                end
            end
            if (req) begin
                rlen++;
                if (rlen == dly[efuse_addr] + 1) begin
                    ack   = 1'b1;
                    rdata = dat[efuse_addr];
                end else begin
                    ack   = 1'b0;
                    rdata = 8'($urandom);
                end
            end else begin
                if (rlen != 0) begin
                    if (exp_req_q.size() == 0) check_val("req_unexpected", rlen, 0);
                    else check_val("req_len", rlen, exp_req_q.pop_front());
                    rlen = 0;
                end
                ack   = force_ack;
                rdata = 8'($urandom);
            end
        end
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) step();
    endtask

    // Run-level model: word w holds req for dly+1 cycles, then one write
    // cycle. A word whose delay reaches TO times out after TO req cycles.
    task automatic plan_run(input int s);
        int t;
        logic [7:0] a;
        t = s;
        end_err = 1'b0;
        for (int w = 0; w < NW; w++) begin
            if (dly[w] >= TO) begin
                exp_req_q.push_back(TO);
                end_cyc = t + TO;
                end_err = 1'b1;
                return;
            end
            a = BASE + 8'(w);
            exp_req_q.push_back(dly[w] + 1);
            exp_q.push_back({32'(t + dly[w] + 1), a, dat[w]});
            t = t + dly[w] + 2;
        end
        end_cyc = t;
    endtask

    task automatic randomize_run(input int maxd);
        for (int w = 0; w < NW; w++) begin
            dly[w] = $urandom_range(0, maxd);
            dat[w] = 8'($urandom);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        s_cyc = cyc + 1;
        step();
        start = 1'b0;
    endtask

    task automatic check_start(input int s);
        wait_cyc(s);
        check_val("start_req", req, 1);
        check_val("start_addr", efuse_addr, 0);
        check_val("start_busy", busy, 1);
        check_val("start_ctrl_en", ctrl_en, 1);
        check_val("start_done", done, 0);
        check_val("start_err", err, 0);
    endtask

    task automatic finish_run();
        wait_cyc(end_cyc - 1);
        check_val("pre_end_busy", busy, 1);
        check_val("pre_end_done", done, 0);
        wait_cyc(end_cyc);
        check_val("end_busy", busy, 0);
        check_val("end_ctrl_en", ctrl_en, 0);
        check_val("end_req", req, 0);
        check_val("end_done", done, !end_err);
        check_val("end_err", err, end_err);
        wait_cyc(end_cyc + 2);
        check_val("wr_left", exp_q.size(), 0);
        check_val("req_left", exp_req_q.size(), 0);
        check_val("sticky_done", done, !end_err);
        check_val("sticky_err", err, end_err);
    endtask

    task automatic check_reset();
        check_val("rst_req", req, 0);
        check_val("rst_efuse_addr", efuse_addr, 0);
        check_val("rst_wen", wen, 0);
        check_val("rst_lgc_addr", lgc_addr, 0);
        check_val("rst_lgc_wdata", lgc_wdata, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_ctrl_en", ctrl_en, 0);
        check_val("rst_done", done, 0);
        check_val("rst_err", err, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int k = 0; k < 256; k++) begin
            dly[k] = 0;
            dat[k] = '0;
        end
        rst_n = 1'b0;
        repeat (3) step();
        check_reset();

        // Run 1: auto start, immediate acks, data A0..A3.
        for (int w = 0; w < NW; w++) begin
            dly[w] = 0;
            dat[w] = 8'hA0 + 8'(w);
        end
        rst_n = 1'b1;
        s_cyc = cyc + 1;
        plan_run(s_cyc);
        check_start(s_cyc);
        finish_run();

        // Run 2: word 1 acked after a 5-cycle wait.
        randomize_run(3);
        dly[1] = 5;
        pulse_start();
        plan_run(s_cyc);
        check_start(s_cyc);
        finish_run();

        // Run 3: word 2 is never acked.
        randomize_run(3);
        dly[2] = 1000;
        pulse_start();
        plan_run(s_cyc);
        check_start(s_cyc);
        wr0 = n_wr;
        finish_run();
        check_val("timeout_writes", n_wr - wr0, 2);

        // Run 4: restart out of ERR; ack arrives on the last allowed cycle.
        randomize_run(TO - 1);
        dly[0] = TO - 1;
        pulse_start();
        plan_run(s_cyc);
        check_start(s_cyc);
        finish_run();

        // Run 5: start pulsed mid-run, then ack pulsed while not requesting.
        randomize_run(3);
        pulse_start();
        plan_run(s_cyc);
        check_start(s_cyc);
        wait_cyc(s_cyc + 3);
        start = 1'b1;
        step();
        start = 1'b0;
        finish_run();
        wr0 = n_wr;
        force_ack = 1'b1;
        repeat (4) step();
        force_ack = 1'b0;
        step();
        check_val("idle_ack_writes", n_wr - wr0, 0);
        check_val("idle_ack_done", done, 1);
        check_val("idle_ack_busy", busy, 0);
        check_val("idle_ack_req", req, 0);

        // Run 6: reset pulse while word 3 is being requested.
        randomize_run(3);
        dly[3] = 4;
        pulse_start();
        plan_run(s_cyc);
        check_start(s_cyc);
        i_wait = 0;
        while (!(req && efuse_addr == 8'd3) && i_wait < 100) begin
            step();
            i_wait++;
        end
        check_val("w3_req_seen", req && efuse_addr == 8'd3, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset();
        exp_q.delete();
        exp_req_q.delete();
        step();
        step();
        randomize_run(3);
        rst_n = 1'b1;
        s_cyc = cyc + 1;
        plan_run(s_cyc);
        check_start(s_cyc);
        finish_run();

        // Randomized runs; a delay of TO means that word times out.
        for (int r = 0; r < 6; r++) begin
            randomize_run(TO);
            pulse_start();
            plan_run(s_cyc);
            check_start(s_cyc);
            finish_run();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    // Time limit for the whole run.
    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
